// File: rtl/axi_lite_write_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite write master port between two requesters.
// Each grant captures the winner's request and runs a single AW/W/B transaction for it.
module axi_lite_write_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [NREQ-1:0]        REQ,
    input  logic [NREQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NREQ*32-1:0]     REQ_DATA,
    input  logic [NREQ*4-1:0]      REQ_STRB,
    input  logic [NREQ*3-1:0]      REQ_PROT,
    output logic [NREQ-1:0]        DONE,
    output logic [1:0]             DONE_RESP,
    output logic                   AWVALID,
    input  logic                   AWREADY,
    output logic [ADDR_W-1:0]      AWADDR,
    output logic [2:0]             AWPROT,
    output logic                   WVALID,
    input  logic                   WREADY,
    output logic [31:0]            WDATA,
    output logic [3:0]             WSTRB,
    input  logic                   BVALID,
    output logic                   BREADY,
    input  logic [1:0]             BRESP
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                lastGrant_q, lastGrant_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [2:0]          awprot_q, awprot_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic [1:0]          doneResp_q, doneResp_d;
    logic                pick;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            lastGrant_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            awaddr_q    <= '0;
            awprot_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            done_q      <= '0;
            doneResp_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            awaddr_q    <= awaddr_d;
            awprot_q    <= awprot_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            done_q      <= done_d;
            doneResp_q  <= doneResp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        awaddr_d    = awaddr_q;
        awprot_d    = awprot_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        done_d      = '0;
        doneResp_d  = doneResp_q;
        // Under contention the requester that did not win last time goes next.
        pick        = (&REQ) ? ~lastGrant_q : REQ[1];

        case (state_q)
            IDLE: begin
                if (|REQ) begin
                    grant_d     = pick;
                    lastGrant_d = pick;
                    awaddr_d    = pick ? REQ_ADDR[ADDR_W +: ADDR_W] : REQ_ADDR[0 +: ADDR_W];
                    awprot_d    = pick ? REQ_PROT[3 +: 3]   : REQ_PROT[0 +: 3];
                    wdata_d     = pick ? REQ_DATA[32 +: 32] : REQ_DATA[0 +: 32];
                    wstrb_d     = pick ? REQ_STRB[4 +: 4]   : REQ_STRB[0 +: 4];
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (awvalid_q && AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (BVALID) begin
                    doneResp_d      = BRESP;
                    done_d[grant_q] = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign AWVALID   = awvalid_q;
    assign WVALID    = wvalid_q;
    assign AWADDR    = awaddr_q;
    assign AWPROT    = awprot_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign BREADY    = (state_q == RESP);
    assign DONE      = done_q;
    assign DONE_RESP = doneResp_q;

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// Randomized scoreboard bench for axi_lite_write_arbiter: requests are queued when raised,
// and a negedge monitor predicts grants, channel handshakes and completions from the rules.
module tb_axi_lite_write_arbiter;

    localparam int ADDR_W = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } txn_t;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b0;
    logic [1:0]        REQ;
    logic [2*ADDR_W-1:0] REQ_ADDR;
    logic [63:0]       REQ_DATA;
    logic [7:0]        REQ_STRB;
    logic [5:0]        REQ_PROT;
    logic [1:0]        DONE;
    logic [1:0]        DONE_RESP;
    logic              AWVALID, AWREADY;
    logic [ADDR_W-1:0] AWADDR;
    logic [2:0]        AWPROT;
    logic              WVALID, WREADY;
    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic              BVALID, BREADY;
    logic [1:0]        BRESP;

    txn_t pay [2];
    txn_t expQ0 [$];
    txn_t expQ1 [$];
    logic [1:0] busy;
    logic [1:0] granted;

    int tests = 0;
    int failures = 0;

    logic       inTxn, awDoneM, wDoneM, bDoneM;
    logic [1:0] bRespM, lastRespM, reqAtEdge;
    logic       lastGrantM, curG;
    txn_t       cur;
    int         txnAge;

    assign REQ_ADDR = {pay[1].addr, pay[0].addr};
    assign REQ_DATA = {pay[1].data, pay[0].data};
    assign REQ_STRB = {pay[1].strb, pay[0].strb};
    assign REQ_PROT = {pay[1].prot, pay[0].prot};

    axi_lite_write_arbiter #(.NREQ(2), .ADDR_W(ADDR_W)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .REQ_STRB(REQ_STRB), .REQ_PROT(REQ_PROT),
        .DONE(DONE), .DONE_RESP(DONE_RESP),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Slave-side bookkeeping: a channel completes on the first edge its ready is seen
    // while the model expects that channel to be outstanding.
    always @(posedge ACLK) begin
        if (!ARESET) begin
            reqAtEdge = REQ;
            if (inTxn) begin
                if (awDoneM && wDoneM && !bDoneM && BVALID) begin
                    bDoneM = 1'b1;
                    bRespM = BRESP;
                end
                if (!awDoneM && AWREADY) awDoneM = 1'b1;
                if (!wDoneM && WREADY)   wDoneM  = 1'b1;
            end
        end
    end

    // Monitor: predicts grant/completion for the cycle just started, then compares all outputs.
    always @(negedge ACLK) begin
        logic [1:0] expDone;
        logic       g;
        if (!ARESET) begin
            expDone = 2'b00;
            if (inTxn && bDoneM) begin
                expDone[curG] = 1'b1;
                lastRespM     = bRespM;
                inTxn         = 1'b0;
            end else if (!inTxn && reqAtEdge != 2'b00) begin
                g          = (reqAtEdge == 2'b11) ? ~lastGrantM : reqAtEdge[1];
                lastGrantM = g;
                curG       = g;
                if (g == 1'b0 && expQ0.size() > 0) begin
                    cur = expQ0.pop_front();
                end else if (g == 1'b1 && expQ1.size() > 0) begin
                    cur = expQ1.pop_front();
                end else begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL grant_src: granted requester %0d, expected one with a queued request", g);
                end
                granted[g] = 1'b1;
                inTxn   = 1'b1;
                awDoneM = 1'b0;
                wDoneM  = 1'b0;
                bDoneM  = 1'b0;
                txnAge  = 0;
            end
            checkOutput("awvalid", AWVALID, inTxn && !awDoneM);
            checkOutput("wvalid", WVALID, inTxn && !wDoneM);
            checkOutput("bready", BREADY, inTxn && awDoneM && wDoneM);
            checkOutput("done", DONE, expDone);
            checkOutput("done_resp", DONE_RESP, lastRespM);
            if (inTxn && !awDoneM) begin
                checkOutput("awaddr", AWADDR, cur.addr);
                checkOutput("awprot", AWPROT, cur.prot);
            end
            if (inTxn && !wDoneM) begin
                checkOutput("wdata", WDATA, cur.data);
                checkOutput("wstrb", WSTRB, cur.strb);
            end
            if (inTxn) begin
                txnAge++;
                if (txnAge > 200) begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL txn_timeout: transaction open %0d cycles, limit 200", txnAge);
                    inTxn = 1'b0;
                end
            end
        end
    end

    task automatic serviceRequesters(input int reqPct, input int scrPct);
        for (int i = 0; i < 2; i++) begin
            if (DONE[i]) begin
                busy[i]    = 1'b0;
                REQ[i]     = 1'b0;
                granted[i] = 1'b0;
            end else if (!busy[i]) begin
                if ($urandom_range(99) < reqPct) begin
                    pay[i].addr = $urandom;
                    pay[i].data = $urandom;
                    pay[i].strb = 4'($urandom_range(15));
                    pay[i].prot = 3'($urandom_range(7));
                    busy[i] = 1'b1;
                    REQ[i]  = 1'b1;
                    if (i == 0) expQ0.push_back(pay[i]);
                    else        expQ1.push_back(pay[i]);
                end
            end else if (granted[i]) begin
                // Request inputs may wander or drop once granted; the transaction must not care.
                if ($urandom_range(99) < scrPct) begin
                    pay[i].addr = $urandom;
                    pay[i].data = $urandom;
                    pay[i].strb = 4'($urandom_range(15));
                    pay[i].prot = 3'($urandom_range(7));
                end
                if ($urandom_range(99) < 5) REQ[i] = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input int cycles, input int reqPct, input int rdyPct,
                                 input int bPct, input int scrPct);
        repeat (cycles) begin
            @(negedge ACLK);
            AWREADY = ($urandom_range(99) < rdyPct);
            WREADY  = ($urandom_range(99) < rdyPct);
            BVALID  = ($urandom_range(99) < bPct);
            BRESP   = 2'($urandom_range(3));
            serviceRequesters(reqPct, scrPct);
        end
    endtask

    task automatic applyReset(input bit midRun);
        int n;
        if (midRun) begin
            n = 0;
            while (BREADY !== 1'b1 && n < 300) begin
                @(negedge ACLK);
                AWREADY = 1'b1;
                WREADY  = 1'b1;
                BVALID  = 1'b0;
                serviceRequesters(100, 0);
                n++;
            end
        end
        #2 ARESET = 1'b1;
        #1;
        checkOutput("rst_awvalid", AWVALID, 1'b0);
        checkOutput("rst_wvalid", WVALID, 1'b0);
        checkOutput("rst_bready", BREADY, 1'b0);
        checkOutput("rst_done", DONE, 2'b00);
        checkOutput("rst_done_resp", DONE_RESP, 2'b00);
        checkOutput("rst_awaddr", AWADDR, 32'h0);
        checkOutput("rst_awprot", AWPROT, 3'h0);
        checkOutput("rst_wdata", WDATA, 32'h0);
        checkOutput("rst_wstrb", WSTRB, 4'h0);
        inTxn      = 1'b0;
        awDoneM    = 1'b0;
        wDoneM     = 1'b0;
        bDoneM     = 1'b0;
        lastGrantM = 1'b1;
        lastRespM  = 2'b00;
        reqAtEdge  = 2'b00;
        txnAge     = 0;
        // An aborted transaction yields no DONE; a requester still asserting REQ is re-served.
        for (int i = 0; i < 2; i++) begin
            granted[i] = 1'b0;
            if (i == 0) expQ0.delete();
            else        expQ1.delete();
            if (busy[i] && REQ[i]) begin
                if (i == 0) expQ0.push_back(pay[i]);
                else        expQ1.push_back(pay[i]);
            end else begin
                busy[i] = 1'b0;
            end
        end
        repeat (3) @(negedge ACLK);
        #2 ARESET = 1'b0;
    endtask

    initial begin
        REQ     = 2'b00;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BRESP   = 2'b00;
        busy    = 2'b00;
        granted = 2'b00;
        for (int i = 0; i < 2; i++) pay[i] = '0;
        inTxn = 1'b0; awDoneM = 1'b0; wDoneM = 1'b0; bDoneM = 1'b0;
        bRespM = 2'b00; lastRespM = 2'b00; reqAtEdge = 2'b00;
        lastGrantM = 1'b1; curG = 1'b0; cur = '0; txnAge = 0;

        applyReset(1'b0);
        applyStimulus(60, 100, 100, 100, 0);
        applyStimulus(400, 40, 50, 50, 20);
        applyReset(1'b1);
        applyStimulus(400, 60, 30, 40, 30);
        applyReset(1'b1);
        applyStimulus(300, 30, 80, 30, 20);
        applyStimulus(300, 0, 70, 70, 0);

        checkOutput("drain_busy", busy, 2'b00);
        checkOutput("drain_open", inTxn, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
